pwm_tcr: RTL and testbench
==========================

Name: pwm_tcr

Overview:
- Timer/compare block for the mini motor project. Directly upstream of the 7-segment stage.
- Generates the motor PWM from a 7-bit duty setting.
- Emits the single-cycle period pulse E, which the 7-segment stage uses to toggle its anode-select flip-flop.
- Qualifies sensor line SnsA as an overcurrent fault: forces PWM off, holds Fault, and enforces a cooldown before restart.

Parameters:
PRESCALE, 4, CLK cycles per PWM counter tick (>=1); PWM period = 128*PRESCALE CLK cycles
SNS_FILT, 3, consecutive synchronized-high SnsA samples required to declare a fault (>=1)
COOL_PERIODS, 2, full PWM periods with SnsA low required before leaving cooldown (>=1)

Ports:
CLK  input  1  system clock; all state on posedge
RST  input  1  asynchronous, active-high reset
Enable  input  1  motor run request, level, synchronous to CLK
Duty  input  7  requested duty, 0..127 = 0/128..127/128
SnsA  input  1  raw sensor input, asynchronous, high = overcurrent
PWM_Out  output  1  motor drive, registered
E  output  1  one-CLK pulse at each PWM period end, registered; feeds the 7-segment stage
Fault  output  1  high while in FAULT or COOL, registered
Cnt  output  7  current PWM counter value, for debug

Behaviour:
- Reset (RST=1, asynchronous):
  - Outputs: PWM_Out=0, E=0, Fault=0, Cnt=0.
  - Internal: prescaler=0, duty shadow=0, SnsA sync flops=0, filter count=0, cooldown count=0, state=IDLE.
- Release of RST takes effect on the first CLK posedge after deassertion.
- Prescaler: counts 0..PRESCALE-1 and wraps. The tick is asserted on the cycle the prescaler equals PRESCALE-1. With PRESCALE=1 the tick is asserted every cycle.
- Counter Cnt:
  - Increments on each tick; wraps 127->0. Free-running in every state.
  - E keeps pulsing even in IDLE and FAULT, so display multiplexing never stops.
- E: asserted for exactly one CLK, on the cycle after the tick that wraps Cnt 127->0. Never wider than one cycle.
- Duty shadow:
  - Loaded from Duty on the same tick that wraps Cnt to 0. Mid-period Duty changes have no effect until the next period.
  - The shadow loads in every state.
- PWM compare (registered): PWM_Out = (state==RUN) && (Cnt < shadow).
  - Duty=0 gives a constant 0.
  - Duty=127 gives high for 127 of 128 counts.
  - PWM_Out lags Cnt by one CLK.
- SnsA synchronizer: 2-flop synchronizer; the filter operates on the second-stage output (snsq).
- Fault filter:
  - Counter increments on each CLK with snsq=1 and clears when snsq=0.
  - A fault is declared when the count reaches SNS_FILT.
  - The filter is active in IDLE and RUN.
- State machine (transitions on CLK):
  - IDLE -> RUN: Enable=1 and no fault declared.
  - RUN -> IDLE: Enable=0.
  - IDLE/RUN -> FAULT: fault declared. Fault has priority over Enable.
  - FAULT -> COOL: snsq=0. Cooldown count is cleared.
  - COOL: cooldown count increments on each E pulse.
  - COOL -> FAULT: snsq=1. Cooldown count is cleared.
  - COOL -> IDLE: cooldown count reaches COOL_PERIODS.
  - Restart always goes through IDLE and needs Enable=1 again on a later cycle. Enable held high restarts one cycle after reaching IDLE.
- Fault output: registered; rises one CLK after entering FAULT, falls one CLK after leaving COOL.
- PWM_Out: drops within one CLK of leaving RUN, including mid-period.
- Simultaneous events:
  - Fault declared and Enable rising in the same cycle: go to FAULT.
  - E pulse and snsq=1 in COOL in the same cycle: go to FAULT; no cooldown credit.
- Reset mid-operation: all state returns to reset values immediately; PWM_Out falls asynchronously.

Test Plan:
1. PRESCALE=1. Reset, then Enable=1, Duty=32 -> E pulses once every 128 CLK, width 1. In each period, PWM_Out is high for 32 CLK and low for 96.
2. Duty changed from 32 to 96 at Cnt=50 -> current period keeps 32 high counts. Next period has 96 high counts, with no glitch at the change.
3. Duty=0 and then Duty=127 -> PWM_Out is constant 0 for Duty=0. For Duty=127 it is high for 127 counts and low only for the count at Cnt=127.
4. SNS_FILT=3: SnsA high for 2 CLK, then low -> no fault. SnsA high for 3 synchronized cycles -> Fault=1, and PWM_Out=0 within one CLK after the declaration. E continues pulsing.
5. COOL_PERIODS=2: SnsA falls, rises again after 1 E pulse, then falls -> the cooldown restarts. Two further clean E pulses -> Fault=0 and state IDLE. With Enable held high, PWM resumes on the next period.
6. Assert RST mid-period with PWM_Out=1 -> PWM_Out, E, Fault and Cnt go to 0 asynchronously. After release, the counter restarts from 0 and the first E pulse comes after 128*PRESCALE CLK.

Source files
------------

// File: rtl/pwm_tcr.sv
// PWM timer/compare block: prescaled 7-bit counter, shadowed duty compare,
// period-end pulse E, and SnsA overcurrent filter with a fault/cooldown FSM.
module pwm_tcr #(
  parameter int PRESCALE     = 4,
  parameter int SNS_FILT     = 3,
  parameter int COOL_PERIODS = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Enable,
  input  logic [6:0] Duty,
  input  logic       SnsA,
  output logic       PWM_Out,
  output logic       E,
  output logic       Fault,
  output logic [6:0] Cnt
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FW = $clog2(SNS_FILT + 1);
  localparam int CW = $clog2(COOL_PERIODS + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [FW-1:0] FILT_MAX   = FW'(SNS_FILT);
  localparam logic [CW-1:0] COOL_LAST  = CW'(COOL_PERIODS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FAULT,
    COOL
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [6:0]    cnt_q, cnt_d;
  logic [6:0]    shadow_q, shadow_d;
  logic          sync1_q, sync1_d;
  logic          snsq_q, snsq_d;
  logic [FW-1:0] filt_q, filt_d;
  logic [CW-1:0] cool_q, cool_d;
  logic          pwm_q, pwm_d;
  logic          e_q, e_d;
  logic          fault_q, fault_d;
  logic          tick;
  logic          wrap;
  logic          fault_det;

  always_comb begin
    tick      = (presc_q == PRESC_LAST);
    presc_d   = tick ? '0 : presc_q + PW'(1);
    wrap      = tick && (cnt_q == 7'd127);
    cnt_d     = tick ? cnt_q + 7'd1 : cnt_q;
    // Duty is sampled only at the period boundary so a period never changes shape mid-way
    shadow_d  = wrap ? Duty : shadow_q;
    e_d       = wrap;
    sync1_d   = SnsA;
    snsq_d    = sync1_q;
    if (!snsq_q) begin
      filt_d = '0;
    end else if (filt_q == FILT_MAX) begin
      filt_d = filt_q;
    end else begin
      filt_d = filt_q + FW'(1);
    end
    fault_det = (filt_d == FILT_MAX);
    pwm_d     = (state_q == RUN) && (cnt_q < shadow_q);
    fault_d   = (state_q == FAULT) || (state_q == COOL);
  end

  // Fault detection wins over Enable; a re-trip during cooldown forfeits earned credit
  always_comb begin
    state_d = state_q;
    cool_d  = cool_q;
    case (state_q)
      IDLE: begin
        if (fault_det) begin
          state_d = FAULT;
        end else if (Enable) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (fault_det) begin
          state_d = FAULT;
        end else if (!Enable) begin
          state_d = IDLE;
        end
      end
      FAULT: begin
        if (!snsq_q) begin
          state_d = COOL;
          cool_d  = '0;
        end
      end
      COOL: begin
        if (snsq_q) begin
          state_d = FAULT;
          cool_d  = '0;
        end else if (e_q) begin
          cool_d = cool_q + CW'(1);
          if (cool_q == COOL_LAST) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      sync1_q  <= 1'b0;
      snsq_q   <= 1'b0;
      filt_q   <= '0;
      cool_q   <= '0;
      pwm_q    <= 1'b0;
      e_q      <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      sync1_q  <= sync1_d;
      snsq_q   <= snsq_d;
      filt_q   <= filt_d;
      cool_q   <= cool_d;
      pwm_q    <= pwm_d;
      e_q      <= e_d;
      fault_q  <= fault_d;
    end
  end

  assign PWM_Out = pwm_q;
  assign E       = e_q;
  assign Fault   = fault_q;
  assign Cnt     = cnt_q;

endmodule

// File: tb/tb_pwm_tcr.sv
// Bench for pwm_tcr: duty table measured per period, then hand sequences for
// overcurrent filtering, cooldown restart and asynchronous reset.
module tb_pwm_tcr;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Enable;
  logic [6:0] Duty;
  logic       SnsA;
  logic       PWM_Out;
  logic       E;
  logic       Fault;
  logic [6:0] Cnt;
  logic       pwm_p4;
  logic       e_p4;
  logic       fault_p4;
  logic [6:0] cnt_p4;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [6:0] duty;
    int         exp_high;
    int         exp_rises;
  } vec_t;

  vec_t vecs [5];

  pwm_tcr #(.PRESCALE(1), .SNS_FILT(3), .COOL_PERIODS(2)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .Enable  (Enable),
    .Duty    (Duty),
    .SnsA    (SnsA),
    .PWM_Out (PWM_Out),
    .E       (E),
    .Fault   (Fault),
    .Cnt     (Cnt)
  );

  pwm_tcr #(.PRESCALE(4), .SNS_FILT(3), .COOL_PERIODS(2)) dut_p4 (
    .CLK     (CLK),
    .RST     (RST),
    .Enable  (Enable),
    .Duty    (Duty),
    .SnsA    (SnsA),
    .PWM_Out (pwm_p4),
    .E       (e_p4),
    .Fault   (fault_p4),
    .Cnt     (cnt_p4)
  );

  always #5 CLK = ~CLK;

  task automatic applyStimulus(input logic en, input logic [6:0] duty, input logic sns);
    Enable = en;
    Duty   = duty;
    SnsA   = sns;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Advance negedge by negedge until E is seen, giving up after 300 cycles
  task automatic waitForE(input string name);
    int n;
    n = 0;
    while (!E && n < 300) begin
      @(negedge CLK);
      n++;
    end
    checkOutput(name, int'(E), 1);
  endtask

  // Starts on the negedge where E is high and samples one full 128-cycle period
  task automatic measurePeriod(input logic [6:0] next_duty, output int highs,
                               output int rises, output int epulses);
    logic prev;
    highs   = 0;
    rises   = 0;
    epulses = 0;
    prev    = 1'b0;
    for (int s = 0; s < 128; s++) begin
      if (PWM_Out) highs++;
      if (PWM_Out && !prev) rises++;
      prev = PWM_Out;
      if (E) epulses++;
      if (Cnt == 7'd50) Duty = next_duty;
      @(negedge CLK);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int         highs;
    int         rises;
    int         epulses;
    int         first_e;
    int         first_e_p4;
    logic [6:0] nxt;

    vecs[0] = '{7'd32,  32,  1};
    vecs[1] = '{7'd96,  96,  1};
    vecs[2] = '{7'd0,   0,   0};
    vecs[3] = '{7'd127, 127, 1};
    vecs[4] = '{7'd1,   1,   1};

    RST = 1'b1;
    applyStimulus(1'b1, vecs[0].duty, 1'b0);
    repeat (3) @(negedge CLK);
    checkOutput("reset PWM_Out", int'(PWM_Out), 0);
    checkOutput("reset E", int'(E), 0);
    checkOutput("reset Fault", int'(Fault), 0);
    checkOutput("reset Cnt", int'(Cnt), 0);
    RST = 1'b0;

    waitForE("first E after reset");
    for (int i = 0; i < 5; i++) begin
      nxt = (i < 4) ? vecs[i+1].duty : 7'd127;
      waitForE("period start E");
      measurePeriod(nxt, highs, rises, epulses);
      checkOutput($sformatf("duty %0d high count", vecs[i].duty), highs, vecs[i].exp_high);
      checkOutput($sformatf("duty %0d rising edges", vecs[i].duty), rises, vecs[i].exp_rises);
      checkOutput($sformatf("duty %0d E pulses", vecs[i].duty), epulses, 1);
    end

    repeat (10) @(negedge CLK);
    applyStimulus(1'b1, 7'd127, 1'b1);
    repeat (2) @(negedge CLK);
    applyStimulus(1'b1, 7'd127, 1'b0);
    repeat (6) @(negedge CLK);
    checkOutput("short SnsA Fault", int'(Fault), 0);
    checkOutput("short SnsA PWM_Out", int'(PWM_Out), 1);

    applyStimulus(1'b1, 7'd127, 1'b1);
    repeat (5) @(negedge CLK);
    checkOutput("Fault before declaration", int'(Fault), 0);
    @(negedge CLK);
    checkOutput("Fault after declaration", int'(Fault), 1);
    checkOutput("PWM_Out in fault", int'(PWM_Out), 0);
    waitForE("E during FAULT");
    checkOutput("Fault held in FAULT", int'(Fault), 1);

    applyStimulus(1'b1, 7'd127, 1'b0);
    repeat (5) @(negedge CLK);
    waitForE("E in first cooldown");
    repeat (5) @(negedge CLK);
    applyStimulus(1'b1, 7'd127, 1'b1);
    repeat (8) @(negedge CLK);
    checkOutput("Fault after re-trip", int'(Fault), 1);
    applyStimulus(1'b1, 7'd127, 1'b0);
    repeat (5) @(negedge CLK);
    waitForE("E one in second cooldown");
    repeat (2) @(negedge CLK);
    checkOutput("cooldown restarted", int'(Fault), 1);
    waitForE("E two in second cooldown");
    @(negedge CLK);
    checkOutput("Fault one cycle after last E", int'(Fault), 1);
    @(negedge CLK);
    checkOutput("Fault released", int'(Fault), 0);

    waitForE("E before resume");
    measurePeriod(7'd127, highs, rises, epulses);
    checkOutput("resume high count", highs, 127);

    repeat (20) @(negedge CLK);
    checkOutput("PWM_Out before reset", int'(PWM_Out), 1);
    RST = 1'b1;
    #1;
    checkOutput("async reset PWM_Out", int'(PWM_Out), 0);
    checkOutput("async reset E", int'(E), 0);
    checkOutput("async reset Fault", int'(Fault), 0);
    checkOutput("async reset Cnt", int'(Cnt), 0);
    checkOutput("async reset Cnt P4", int'(cnt_p4), 0);
    checkOutput("async reset PWM_Out P4", int'(pwm_p4), 0);
    checkOutput("async reset E P4", int'(e_p4), 0);
    checkOutput("async reset Fault P4", int'(fault_p4), 0);
    @(negedge CLK);
    RST = 1'b0;

    first_e    = -1;
    first_e_p4 = -1;
    for (int n = 1; n <= 600; n++) begin
      @(negedge CLK);
      if (n == 10) begin
        checkOutput("Cnt 10 cycles after reset", int'(Cnt), 10);
        checkOutput("Cnt P4 10 cycles after reset", int'(cnt_p4), 2);
      end
      if (E && first_e < 0) first_e = n;
      if (e_p4 && first_e_p4 < 0) first_e_p4 = n;
    end
    checkOutput("first E cycle after reset", first_e, 128);
    checkOutput("first E cycle after reset P4", first_e_p4, 512);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
